// File: rtl/flow_lookup.sv
// flow_lookup: exact-match flow table with a sequential (one entry per cycle)
// search engine. A lookup is triggered by a rising edge of headers_valid; the
// result is held on result_* until acknowledged. A second request arriving
// while busy is parked in a one-deep pending slot; further ones are dropped.
//
// Optional build macro OF_LOOKUP_STATS_EN adds saturating 32-bit hit, miss
// and drop counters as extra output ports.

`ifndef OF_HEADER_REG_WIDTH
`define OF_HEADER_REG_WIDTH 64
`endif

module flow_lookup #(
  parameter int HEADER_WIDTH = `OF_HEADER_REG_WIDTH,
  parameter int NUM_ENTRIES  = 8,
  parameter int ACTION_WIDTH = 32,
  localparam int IDX_WIDTH   = $clog2(NUM_ENTRIES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [HEADER_WIDTH-1:0] header_bus,
  input  logic                    headers_valid,
  input  logic                    tbl_wr,
  input  logic [IDX_WIDTH-1:0]    tbl_wr_index,
  input  logic [HEADER_WIDTH-1:0] tbl_wr_key,
  input  logic [ACTION_WIDTH-1:0] tbl_wr_action,
  input  logic                    tbl_wr_valid,
  output logic                    result_valid,
  input  logic                    result_ack,
  output logic                    result_hit,
  output logic [IDX_WIDTH-1:0]    result_index,
  output logic [ACTION_WIDTH-1:0] result_action
`ifdef OF_LOOKUP_STATS_EN
  ,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count,
  output logic [31:0]             drop_count
`endif
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_ENTRIES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    RESULT
  } state_e;

  // Table storage
  logic [NUM_ENTRIES-1:0]  ent_valid_q;
  logic [HEADER_WIDTH-1:0] ent_key_q    [NUM_ENTRIES];
  logic [ACTION_WIDTH-1:0] ent_action_q [NUM_ENTRIES];

  // Search engine state
  state_e                  state_q, state_d;
  logic                    hv_q;
  logic [HEADER_WIDTH-1:0] key_q, key_d;
  logic [IDX_WIDTH-1:0]    idx_q, idx_d;
  logic                    first_q, first_d;   // warm-up cycle before entry 0
  logic                    pend_q, pend_d;
  logic [HEADER_WIDTH-1:0] pend_key_q, pend_key_d;

  // Result registers
  logic                    rv_q, rv_d;
  logic                    hit_q, hit_d;
  logic [IDX_WIDTH-1:0]    index_q, index_d;
  logic [ACTION_WIDTH-1:0] action_q, action_d;

  logic req;
  logic ent_match;
  logic queue_req;

  assign req       = headers_valid & ~hv_q;
  assign ent_match = ent_valid_q[idx_q] && (ent_key_q[idx_q] == key_q);

  // Entry valid bits: cleared by reset, written by the table write port.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; this is what makes a same-cycle write invisible to the
  // compare of that entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_valid_q <= '0;
    end else if (tbl_wr) begin
      ent_valid_q[tbl_wr_index] <= tbl_wr_valid;
    end
  end

  // Entry key/action storage written by the table write port.
  // NOTE: key/action arrays are deliberately left out of reset; an entry is
  // only ever consulted through its valid bit, which is reset.
  always_ff @(posedge clk) begin
    if (tbl_wr) begin
      ent_key_q[tbl_wr_index]    <= tbl_wr_key;
      ent_action_q[tbl_wr_index] <= tbl_wr_action;
    end
  end

  // State, key, pending-slot and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      hv_q       <= 1'b0;
      key_q      <= '0;
      idx_q      <= '0;
      first_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_key_q <= '0;
      rv_q       <= 1'b0;
      hit_q      <= 1'b0;
      index_q    <= '0;
      action_q   <= '0;
    end else begin
      state_q    <= state_d;
      hv_q       <= headers_valid;
      key_q      <= key_d;
      idx_q      <= idx_d;
      first_q    <= first_d;
      pend_q     <= pend_d;
      pend_key_q <= pend_key_d;
      rv_q       <= rv_d;
      hit_q      <= hit_d;
      index_q    <= index_d;
      action_q   <= action_d;
    end
  end

  // Next-state logic: request start, one-entry-per-cycle search, result
  // handshake and pending-slot management.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    key_d      = key_q;
    idx_d      = idx_q;
    first_d    = first_q;
    pend_d     = pend_q;
    pend_key_d = pend_key_q;
    rv_d       = rv_q;
    hit_d      = hit_q;
    index_d    = index_q;
    action_d   = action_q;
    queue_req  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = SEARCH;
          key_d   = header_bus;
          idx_d   = '0;
          first_d = 1'b1;
        end
      end

      SEARCH: begin
        queue_req = req;
        if (first_q) begin
          first_d = 1'b0;
        end else if (ent_match) begin
          state_d  = RESULT;
          rv_d     = 1'b1;
          hit_d    = 1'b1;
          index_d  = idx_q;
          action_d = ent_action_q[idx_q];
        end else if (idx_q == LAST_IDX) begin
          state_d  = RESULT;
          rv_d     = 1'b1;
          hit_d    = 1'b0;
          index_d  = '0;
          action_d = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      RESULT: begin
        if (result_ack) begin
          rv_d = 1'b0;
          if (pend_q) begin
            // The parked request wins; a request on this same edge finds the
            // slot still occupied and is dropped below.
            state_d   = SEARCH;
            key_d     = pend_key_q;
            idx_d     = '0;
            first_d   = 1'b1;
            pend_d    = 1'b0;
            queue_req = req;
          end else if (req) begin
            state_d = SEARCH;
            key_d   = header_bus;
            idx_d   = '0;
            first_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          queue_req = req;
        end
      end

      default: state_d = IDLE;
    endcase

    // Busy: park the request if the slot is free, otherwise it is dropped.
    if (queue_req && !pend_q) begin
      pend_d     = 1'b1;
      pend_key_d = header_bus;
    end
  end

  assign result_valid  = rv_q;
  assign result_hit    = hit_q;
  assign result_index  = index_q;
  assign result_action = action_q;

`ifdef OF_LOOKUP_STATS_EN
  logic        hit_evt, miss_evt, drop_evt;
  logic [31:0] hit_cnt_q, miss_cnt_q, drop_cnt_q;

  assign hit_evt  = (state_q == SEARCH) && !first_q && ent_match;
  assign miss_evt = (state_q == SEARCH) && !first_q && !ent_match && (idx_q == LAST_IDX);
  // The slot is never occupied in IDLE, so any request seeing it full is lost.
  assign drop_evt = req && pend_q;

  // Saturating event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (hit_evt  && (hit_cnt_q  != '1)) hit_cnt_q  <= hit_cnt_q  + 32'd1;
      if (miss_evt && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (drop_evt && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_flow_lookup.sv
// Testbench for flow_lookup: directed stimulus with a scoreboard queue of
// expected results consumed by an independent monitor on the falling edge.

module tb_flow_lookup;

  localparam int HW = 64;
  localparam int NE = 8;
  localparam int AW = 32;
  localparam int IW = 3;

  localparam logic [HW-1:0] KA = 64'hDEAD_BEEF_0123_4567;
  localparam logic [HW-1:0] KB = 64'h0F0F_1234_AAAA_5555;
  localparam logic [HW-1:0] KC = 64'h1111_2222_3333_4444;
  localparam logic [HW-1:0] K0 = 64'hFFFF_0000_FFFF_0000;

  logic          clk;
  logic          reset;
  logic [HW-1:0] header_bus;
  logic          headers_valid;
  logic          tbl_wr;
  logic [IW-1:0] tbl_wr_index;
  logic [HW-1:0] tbl_wr_key;
  logic [AW-1:0] tbl_wr_action;
  logic          tbl_wr_valid;
  logic          result_valid;
  logic          result_ack;
  logic          result_hit;
  logic [IW-1:0] result_index;
  logic [AW-1:0] result_action;
`ifdef OF_LOOKUP_STATS_EN
  logic [31:0]   hit_count, miss_count, drop_count;
`endif

  flow_lookup #(
    .HEADER_WIDTH (HW),
    .NUM_ENTRIES  (NE),
    .ACTION_WIDTH (AW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .header_bus    (header_bus),
    .headers_valid (headers_valid),
    .tbl_wr        (tbl_wr),
    .tbl_wr_index  (tbl_wr_index),
    .tbl_wr_key    (tbl_wr_key),
    .tbl_wr_action (tbl_wr_action),
    .tbl_wr_valid  (tbl_wr_valid),
    .result_valid  (result_valid),
    .result_ack    (result_ack),
    .result_hit    (result_hit),
    .result_index  (result_index),
    .result_action (result_action)
`ifdef OF_LOOKUP_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count),
    .drop_count    (drop_count)
`endif
  );

  typedef struct {
    logic          hit;
    logic [IW-1:0] idx;
    logic [AW-1:0] act;
    int            rise_cyc;   // edge count at which result_valid must rise
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  logic rv_prev = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares the presented result against the scoreboard head every
  // cycle it is valid (latency on the rising cycle), pops on acceptance.
  always @(negedge clk) begin
    if (reset) begin
      rv_prev = 1'b0;
    end else begin
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result: got hit=%0b idx=%0d act=%0h expected none (cycle %0d)",
                   result_hit, result_index, result_action, cyc);
        end else begin
          if (!rv_prev) check("latency", 64'(cyc), 64'(exp_q[0].rise_cyc));
          check("result_hit", 64'(result_hit), 64'(exp_q[0].hit));
          check("result_index", 64'(result_index), 64'(exp_q[0].idx));
          check("result_action", 64'(result_action), 64'(exp_q[0].act));
          if (result_ack) void'(exp_q.pop_front());
        end
      end
      rv_prev = result_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic hit, input logic [IW-1:0] idx, input logic [AW-1:0] act,
                          input int rise);
    exp_t e;
    e.hit = hit; e.idx = idx; e.act = act; e.rise_cyc = rise;
    exp_q.push_back(e);
  endtask

  task automatic write_entry(input logic [IW-1:0] idx, input logic [HW-1:0] key,
                             input logic [AW-1:0] act, input logic v);
    tbl_wr = 1'b1; tbl_wr_index = idx; tbl_wr_key = key; tbl_wr_action = act; tbl_wr_valid = v;
    tick();
    tbl_wr = 1'b0;
  endtask

  // One-cycle headers_valid pulse; returns the edge number that detects it.
  task automatic request(input logic [HW-1:0] key, output int req_edge);
    header_bus = key;
    headers_valid = 1'b1;
    req_edge = cyc + 1;
    tick();
    headers_valid = 1'b0;
  endtask

  task automatic wait_result(input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (result_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("result_seen", 64'(found), 64'd1);
  endtask

  task automatic wait_and_ack(input int budget);
    wait_result(budget);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, a;
    reset = 1'b1;
    header_bus = '0; headers_valid = 1'b0; result_ack = 1'b0;
    tbl_wr = 1'b0; tbl_wr_index = '0; tbl_wr_key = '0; tbl_wr_action = '0; tbl_wr_valid = 1'b0;
    repeat (3) tick();
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_hit", 64'(result_hit), 64'd0);
    check("rst_index", 64'(result_index), 64'd0);
    check("rst_action", 64'(result_action), 64'd0);
    reset = 1'b0;
    tick();

    // Empty table: miss after NE+1 edges.
    request(K0, r); push_exp(1'b0, '0, '0, r + NE + 1);
    wait_and_ack(20);

    // Entry 3 hit: result 5 edges after the request edge.
    write_entry(3'd3, KA, 32'hA3A3_0003, 1'b1);
    request(KA, r); push_exp(1'b1, 3'd3, 32'hA3A3_0003, r + 5);
    wait_and_ack(20);

    // Duplicate key in 2 and 5: lowest index wins.
    write_entry(3'd2, KB, 32'hB2B2_0002, 1'b1);
    write_entry(3'd5, KB, 32'hB5B5_0005, 1'b1);
    request(KB, r); push_exp(1'b1, 3'd2, 32'hB2B2_0002, r + 4);
    wait_and_ack(20);

    // Key differing only in the MSB must miss.
    request(KA ^ {1'b1, 63'd0}, r); push_exp(1'b0, '0, '0, r + NE + 1);
    wait_and_ack(20);

    // Entry 0 deleted in its own compare cycle: still hits, then misses.
    write_entry(3'd0, KC, 32'hC0C0_0000, 1'b1);
    request(KC, r); push_exp(1'b1, 3'd0, 32'hC0C0_0000, r + 2);
    tick();
    write_entry(3'd0, KC, 32'h0, 1'b0);
    wait_and_ack(20);
    request(KC, r); push_exp(1'b0, '0, '0, r + NE + 1);
    wait_and_ack(20);

    // ack while idle is ignored (monitor flags any spurious result).
    result_ack = 1'b1;
    repeat (3) tick();
    result_ack = 1'b0;
    check("idle_ack_ignored", 64'(result_valid), 64'd0);

    // Held result, one pending request served after ack, one dropped.
    request(KA, r); push_exp(1'b1, 3'd3, 32'hA3A3_0003, r + 5);
    wait_result(20);
    tick();
    request(KB, r);
    tick();
    request(KC, r);
    repeat (6) tick();
    result_ack = 1'b1;
    a = cyc + 1;
    push_exp(1'b1, 3'd2, 32'hB2B2_0002, a + 4);
    tick();
    result_ack = 1'b0;
    check("valid_drops_on_ack", 64'(result_valid), 64'd0);
    wait_and_ack(20);
    repeat (12) tick();
    check("dropped_not_served", 64'(result_valid), 64'd0);
`ifdef OF_LOOKUP_STATS_EN
    check("drop_count", 64'(drop_count), 64'd1);
`endif

    // Request and ack on the same edge with empty slot: direct restart.
    request(KA, r); push_exp(1'b1, 3'd3, 32'hA3A3_0003, r + 5);
    wait_result(20);
    result_ack = 1'b1;
    header_bus = KB;
    headers_valid = 1'b1;
    a = cyc + 1;
    push_exp(1'b1, 3'd2, 32'hB2B2_0002, a + 4);
    tick();
    result_ack = 1'b0;
    headers_valid = 1'b0;
    wait_and_ack(20);

    // Reset mid-search abandons the lookup and invalidates the table.
    request(KA, r);
    tick();
    #2 reset = 1'b1;
    exp_q.delete();
    #1 check("async_rst_valid", 64'(result_valid), 64'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 7) check("no_result_after_rst", 64'(result_valid), 64'd0);
    end
    request(KA, r); push_exp(1'b0, '0, '0, r + NE + 1);
    wait_and_ack(20);
`ifdef OF_LOOKUP_STATS_EN
    check("miss_count_after_rst", 64'(miss_count), 64'd1);
    check("hit_count_after_rst", 64'(hit_count), 64'd0);
`endif

    repeat (3) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
